alu_operand_stage: RTL and testbench
====================================

ALU_OPERAND_STAGE -- requirements
Module: alu_operand_stage

Interface
REQ-001 The block SHALL have one clock and a synchronous, active-high reset: CLK input 1 (rising-edge clock for all state); RST input 1 (synchronous, active-high reset).
REQ-002 Upstream handshake SHALL be: IN_VALID input 1 (operand bundle present); IN_READY output 1 (stage can accept a bundle).
REQ-003 Operand inputs SHALL be: RS1 input 32 (register source 1); RS2 input 32 (register source 2); PC input 32 (instruction address); IMM input 32 (sign-extended or U-type immediate).
REQ-004 Select inputs SHALL be: SRCA_SEL input 2 (0=RS1, 1=IMM, 2=PC, 3=zero); SRCB_SEL input 3 (0=RS2, 1=IMM, 2=PC, 3=constant 4, 4-7=zero).
REQ-005 Tag inputs SHALL be: FUN_IN input 4 (ALU function code); RD_IN input 5 (destination register tag).
REQ-006 FLUSH SHALL be an input of width 1 that discards all held and incoming bundles.
REQ-007 Downstream handshake SHALL be: OUT_VALID output 1 (bundle present); OUT_READY input 1 (ALU side consumes bundle).
REQ-008 Output payload SHALL be: A output 32; B output 32; ALU_FUN output 4; RD_OUT output 5; ILLEGAL output 1 (FUN_IN was not a legal code).

Function
REQ-009 The stage SHALL resolve operands at acceptance time: A = mux(SRCA_SEL), B = mux(SRCB_SEL), per REQ-004, using the input values present on the accepting edge.
REQ-010 Legal function codes SHALL be 0000, 1000, 0110, 0111, 0100, 0101, 0001, 1101, 0010, 0011 and 1001; any other code SHALL be stored as ALU_FUN=0000 with ILLEGAL=1.
REQ-011 An input transfer SHALL occur on a rising edge with IN_VALID=1, IN_READY=1, RST=0 and FLUSH=0.
REQ-012 An output transfer SHALL occur on a rising edge with OUT_VALID=1 and OUT_READY=1.
REQ-013 Storage SHALL be two entries: an output register (drives A/B/ALU_FUN/RD_OUT/ILLEGAL/OUT_VALID) and a skid register.
REQ-014 IN_READY SHALL equal NOT(skid valid) AND NOT RST; it SHALL depend on no other input combinationally.
REQ-015 On an input transfer, if the output register is empty or transfers out on the same edge, and the skid register is empty, the bundle SHALL load into the output register.
REQ-016 On an input transfer where the output register is full and not transferring out, the bundle SHALL load into the skid register.
REQ-017 On an output transfer with the skid register full, the skid contents SHALL move to the output register and the skid SHALL become empty on that edge.
REQ-018 On an output transfer with the skid register empty and no input transfer, OUT_VALID SHALL go to 0.
REQ-019 Bundles SHALL leave in acceptance order; none SHALL be duplicated or dropped except by FLUSH or RST.
REQ-020 Output payload SHALL hold stable while OUT_VALID=1 and OUT_READY=0.
REQ-021 Latency SHALL be one cycle: a bundle accepted into an empty stage SHALL appear with OUT_VALID=1 on the following cycle.
REQ-022 Sustained throughput with OUT_READY=1 SHALL be one bundle per cycle.
REQ-023 FLUSH=1 on an edge SHALL clear both entries' valid bits and SHALL discard any bundle offered that cycle; an output transfer on that edge SHALL still count as consumed.
REQ-024 Payload registers MAY retain stale data when invalid, except where REQ-025 forces zero.

Reset
REQ-025 RST=1 on an edge SHALL set OUT_VALID=0, skid valid=0, A=0, B=0, ALU_FUN=0000, RD_OUT=0 and ILLEGAL=0.
REQ-026 IN_READY SHALL be 0 while RST=1 and 1 on the first cycle after RST falls.
REQ-027 RST SHALL take priority over FLUSH and all transfers, including when asserted with both entries full.

Verification
REQ-028 Basic pass: RS1=5, IMM=7, SRCA_SEL=0, SRCB_SEL=1, FUN_IN=0000, RD_IN=3, accepted with OUT_READY=1 -> next cycle A=5, B=7, ALU_FUN=0000, RD_OUT=3, OUT_VALID=1.
REQ-029 Back-pressure: OUT_READY=0, three bundles offered back-to-back -> two are accepted, IN_READY=0 on the third cycle; after OUT_READY=1 the bundles exit in order with no loss.
REQ-030 Illegal code: FUN_IN=1111 -> ALU_FUN=0000 and ILLEGAL=1; FUN_IN=1101 -> ALU_FUN=1101 and ILLEGAL=0.
REQ-031 Selects: PC=0x100, SRCA_SEL=2, SRCB_SEL=3 -> A=0x100, B=4; SRCA_SEL=3 with SRCB_SEL=6 -> A=0, B=0.
REQ-032 Flush: both entries full and IN_VALID=1 with FLUSH=1 -> next cycle OUT_VALID=0, IN_READY=1, and the offered bundle never appears.
REQ-033 Reset mid-stream: RST=1 with both entries full -> all outputs zero, OUT_VALID=0, IN_READY=0 while RST=1, IN_READY=1 on the cycle after release.

Source files
------------

// File: rtl/alu_operand_stage.sv
// alu_operand_stage: resolves ALU operands on acceptance, then holds them in a two-entry output+skid buffer
module alu_operand_stage (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] rs1,
  input  logic [31:0] rs2,
  input  logic [31:0] pc,
  input  logic [31:0] imm,
  input  logic [1:0]  srca_sel,
  input  logic [2:0]  srcb_sel,
  input  logic [3:0]  fun_in,
  input  logic [4:0]  rd_in,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [3:0]  alu_fun,
  output logic [4:0]  rd_out,
  output logic        illegal
);
  logic [73:0] in_bundle, out_bundle, skid_bundle;
  logic [31:0] in_a, in_b;
  logic        legal, skid_valid, in_xfer, out_xfer;
  always_comb begin
    in_a = srca_sel == 2'd0 ? rs1 : srca_sel == 2'd1 ? imm : srca_sel == 2'd2 ? pc : 32'd0;
    in_b = srcb_sel == 3'd0 ? rs2 : srcb_sel == 3'd1 ? imm : srcb_sel == 3'd2 ? pc :
           srcb_sel == 3'd3 ? 32'd4 : 32'd0;
    legal = !(fun_in inside {4'd10, 4'd11, 4'd12, 4'd14, 4'd15});
    in_bundle = {in_a, in_b, legal ? fun_in : 4'd0, rd_in, !legal};
  end
  assign in_ready = !skid_valid && !rst;
  assign in_xfer  = in_valid && in_ready && !flush;
  assign out_xfer = out_valid && out_ready;
  assign {a, b, alu_fun, rd_out, illegal} = out_bundle;
  always_ff @(posedge clk) begin
    if (rst) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
      out_bundle <= '0;
    end else if (flush) begin
      out_valid  <= 1'b0;
      skid_valid <= 1'b0;
    end else if (out_xfer || !out_valid) begin
      // skid is only ever full while in_ready is low, so it never competes with a new input
      if (skid_valid) begin
        out_bundle <= skid_bundle;
        out_valid  <= 1'b1;
        skid_valid <= 1'b0;
      end else begin
        if (in_xfer) out_bundle <= in_bundle;
        out_valid <= in_xfer;
      end
    end else if (in_xfer) begin
      skid_bundle <= in_bundle;
      skid_valid  <= 1'b1;
    end
  end
endmodule

// File: tb/tb_alu_operand_stage.sv
// tb_alu_operand_stage: directed vectors with hand-computed expectations for alu_operand_stage
module tb_alu_operand_stage;
  logic        clk = 0, rst = 1, in_valid = 0, in_ready, flush = 0, out_valid, out_ready = 1, illegal;
  logic [31:0] rs1 = 0, rs2 = 0, pc = 0, imm = 0, a, b;
  logic [1:0]  srca_sel = 0;
  logic [2:0]  srcb_sel = 0;
  logic [3:0]  fun_in = 0, alu_fun;
  logic [4:0]  rd_in = 0, rd_out;
  int n_vec = 0, n_bad = 0;

  alu_operand_stage dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .rs1(rs1), .rs2(rs2), .pc(pc), .imm(imm), .srca_sel(srca_sel), .srcb_sel(srcb_sel),
    .fun_in(fun_in), .rd_in(rd_in), .flush(flush), .out_valid(out_valid), .out_ready(out_ready),
    .a(a), .b(b), .alu_fun(alu_fun), .rd_out(rd_out), .illegal(illegal)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic offer(input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] p,
                       input logic [31:0] im, input logic [1:0] sa, input logic [2:0] sb,
                       input logic [3:0] fn, input logic [4:0] rd);
    in_valid = 1; rs1 = r1; rs2 = r2; pc = p; imm = im;
    srca_sel = sa; srcb_sel = sb; fun_in = fn; rd_in = rd;
  endtask

  initial begin
    tick(); tick();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_a", a, 0);
    chk("rst_b", b, 0);
    chk("rst_fun", alu_fun, 0);
    chk("rst_rd", rd_out, 0);
    chk("rst_ill", illegal, 0);
    rst = 0;
    #1 chk("rel_in_ready", in_ready, 1);

    offer(5, 0, 0, 7, 0, 1, 4'b0000, 3);
    tick();
    chk("basic_valid", out_valid, 1);
    chk("basic_a", a, 5);
    chk("basic_b", b, 7);
    chk("basic_fun", alu_fun, 0);
    chk("basic_rd", rd_out, 3);
    offer(1, 2, 3, 4, 0, 0, 4'b1111, 6);
    tick();
    chk("ill_valid", out_valid, 1);
    chk("ill_fun", alu_fun, 0);
    chk("ill_flag", illegal, 1);
    chk("ill_rd", rd_out, 6);
    chk("ill_b_rs2", b, 2);
    offer(1, 2, 3, 4, 0, 0, 4'b1101, 7);
    tick();
    chk("leg_fun", alu_fun, 4'b1101);
    chk("leg_flag", illegal, 0);
    offer(9, 9, 32'h100, 9, 2, 3, 4'b0110, 8);
    tick();
    chk("sel_pc_a", a, 32'h100);
    chk("sel_four_b", b, 4);
    chk("sel_fun", alu_fun, 4'b0110);
    offer(9, 9, 32'h100, 9, 3, 6, 4'b1001, 9);
    tick();
    chk("sel_zero_a", a, 0);
    chk("sel_zero_b", b, 0);
    offer(9, 9, 32'h200, 32'h33, 1, 2, 4'b0011, 10);
    tick();
    chk("sel_imm_a", a, 32'h33);
    chk("sel_pc_b", b, 32'h200);
    in_valid = 0;
    tick();
    chk("drain_valid", out_valid, 0);

    out_ready = 0;
    offer(32'h11, 0, 0, 0, 0, 0, 0, 1);
    tick();
    offer(32'h22, 0, 0, 0, 0, 0, 0, 2);
    chk("bp_ready2", in_ready, 1);
    tick();
    offer(32'h33, 0, 0, 0, 0, 0, 0, 3);
    chk("bp_ready3", in_ready, 0);
    tick();
    chk("bp_hold_rd", rd_out, 1);
    chk("bp_hold_a", a, 32'h11);
    out_ready = 1;
    tick();
    chk("bp_out2_rd", rd_out, 2);
    chk("bp_out2_a", a, 32'h22);
    tick();
    chk("bp_out3_rd", rd_out, 3);
    chk("bp_out3_v", out_valid, 1);
    in_valid = 0;
    tick();
    chk("bp_empty", out_valid, 0);

    out_ready = 0;
    offer(32'h44, 0, 0, 0, 0, 0, 0, 4);
    tick();
    offer(32'h55, 0, 0, 0, 0, 0, 0, 5);
    tick();
    offer(32'h99, 0, 0, 0, 0, 0, 0, 9);
    flush = 1;
    tick();
    flush = 0; in_valid = 0; out_ready = 1;
    chk("fl_valid", out_valid, 0);
    chk("fl_ready", in_ready, 1);
    tick();
    chk("fl_gone", out_valid, 0);

    out_ready = 0;
    offer(32'h66, 6, 0, 0, 0, 0, 4'b0111, 6);
    tick();
    offer(32'h77, 7, 0, 0, 0, 0, 4'b0111, 7);
    tick();
    in_valid = 0;
    rst = 1;
    #1 chk("mrst_ready_hi", in_ready, 0);
    tick();
    chk("mrst_valid", out_valid, 0);
    chk("mrst_a", a, 0);
    chk("mrst_b", b, 0);
    chk("mrst_fun", alu_fun, 0);
    chk("mrst_rd", rd_out, 0);
    chk("mrst_ready", in_ready, 0);
    rst = 0;
    #1 chk("mrst_rel", in_ready, 1);
    tick();
    chk("mrst_still_empty", out_valid, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
